// File: rtl/adc_pkg.sv
// Shared definitions for the MAX10 ADC command/response sequencer.
package adc_pkg;

    localparam int unsigned CHANNEL_WIDTH      = 5;
    localparam int unsigned DEFAULT_DATA_WIDTH = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/adc_sample_timer.sv
// Sample-period counter: ticks once every sample_period+1 cycles while enabled.
module adc_sample_timer
    import adc_pkg::*;
#(
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] sample_period,
    output logic                    tick
);

    logic [PERIOD_WIDTH-1:0] count_q, count_d;

    // >= keeps the counter from running past a period that was lowered mid-count
    always_comb begin
        tick    = 1'b0;
        count_d = count_q + PERIOD_WIDTH'(1);
        if (!enable) begin
            count_d = '0;
        end else if (count_q >= sample_period) begin
            tick    = 1'b1;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/adc_sequencer.sv
// Issues timed packets of channel conversions to the MAX10 ADC and steers
// each returned result into its per-slot register.
module adc_sequencer
    import adc_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned PERIOD_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [NUM_SLOTS*CHANNEL_WIDTH-1:0] slot_channels,
    input  logic [2:0]                         slot_count,
    input  logic [PERIOD_WIDTH-1:0]            sample_period,
    input  logic                               clear_flags,
    output logic                               command_valid,
    output logic [CHANNEL_WIDTH-1:0]           command_channel,
    output logic                               command_startofpacket,
    output logic                               command_endofpacket,
    input  logic                               command_ready,
    input  logic                               response_valid,
    input  logic [CHANNEL_WIDTH-1:0]           response_channel,
    input  logic [DATA_WIDTH-1:0]              response_data,
    output logic [NUM_SLOTS*DATA_WIDTH-1:0]    result_data,
    output logic [2:0]                         result_slot,
    output logic                               result_stb,
    output logic                               seq_done,
    output logic                               busy,
    output logic                               overrun,
    output logic                               chan_err
);

    logic tick;

    adc_sample_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_period (sample_period),
        .tick          (tick)
    );

    state_t                   state_q;
    logic [2:0]               iss_idx_q, rsp_idx_q, cnt_q;
    logic [CHANNEL_WIDTH-1:0] chan_q [NUM_SLOTS];
    logic [DATA_WIDTH-1:0]    res_q  [NUM_SLOTS];
    logic                     cmd_valid_q, cmd_sop_q, cmd_eop_q;
    logic [CHANNEL_WIDTH-1:0] cmd_chan_q;
    logic [2:0]               res_slot_q;
    logic                     res_stb_q, seq_done_q, overrun_q, chan_err_q;

    logic [2:0]               cnt_in, iss_nxt;
    logic [CHANNEL_WIDTH-1:0] next_chan, exp_chan;
    logic                     cmd_fire, rsp_take, rsp_orphan, rsp_mismatch;

    always_comb begin
        cnt_in = ({1'b0, slot_count} > 4'(NUM_SLOTS)) ? 3'(NUM_SLOTS) : slot_count;
        iss_nxt = iss_idx_q + 3'd1;
        next_chan = '0;
        exp_chan  = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            if (iss_nxt == 3'(k))   next_chan = chan_q[k];
            if (rsp_idx_q == 3'(k)) exp_chan  = chan_q[k];
        end
    end

    // rsp_idx never passes iss_idx, so inequality means conversions are outstanding
    assign cmd_fire     = cmd_valid_q && command_ready;
    assign rsp_take     = response_valid && (rsp_idx_q != iss_idx_q);
    assign rsp_orphan   = response_valid && !rsp_take;
    assign rsp_mismatch = rsp_take && (response_channel != exp_chan);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            iss_idx_q   <= '0;
            rsp_idx_q   <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_chan_q  <= '0;
            cmd_sop_q   <= 1'b0;
            cmd_eop_q   <= 1'b0;
            res_slot_q  <= '0;
            res_stb_q   <= 1'b0;
            seq_done_q  <= 1'b0;
            overrun_q   <= 1'b0;
            chan_err_q  <= 1'b0;
            for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                chan_q[k] <= '0;
                res_q[k]  <= '0;
            end
        end else begin
            res_stb_q  <= rsp_take;
            seq_done_q <= 1'b0;

            if (rsp_take) begin
                for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                    if (rsp_idx_q == 3'(k)) res_q[k] <= response_data;
                end
                res_slot_q <= rsp_idx_q;
                rsp_idx_q  <= rsp_idx_q + 3'd1;
            end

            if (tick && (state_q != IDLE)) overrun_q <= 1'b1;
            else if (clear_flags)          overrun_q <= 1'b0;

            if (rsp_orphan || rsp_mismatch) chan_err_q <= 1'b1;
            else if (clear_flags)           chan_err_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (tick && (cnt_in != 3'd0)) begin
                        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
                            chan_q[k] <= slot_channels[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                        end
                        cnt_q       <= cnt_in;
                        iss_idx_q   <= '0;
                        rsp_idx_q   <= '0;
                        cmd_valid_q <= 1'b1;
                        cmd_chan_q  <= slot_channels[CHANNEL_WIDTH-1:0];
                        cmd_sop_q   <= 1'b1;
                        cmd_eop_q   <= (cnt_in == 3'd1);
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_fire) begin
                        iss_idx_q <= iss_nxt;
                        cmd_sop_q <= 1'b0;
                        if (iss_idx_q == cnt_q - 3'd1) begin
                            cmd_valid_q <= 1'b0;
                            cmd_chan_q  <= '0;
                            cmd_eop_q   <= 1'b0;
                            state_q     <= DRAIN;
                        end else begin
                            cmd_chan_q <= next_chan;
                            cmd_eop_q  <= (iss_nxt == cnt_q - 3'd1);
                        end
                    end
                end
                DRAIN: begin
                    if (rsp_idx_q == cnt_q) begin
                        seq_done_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        result_data = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            result_data[k*DATA_WIDTH +: DATA_WIDTH] = res_q[k];
        end
    end

    assign command_valid         = cmd_valid_q;
    assign command_channel       = cmd_chan_q;
    assign command_startofpacket = cmd_sop_q;
    assign command_endofpacket   = cmd_eop_q;
    assign result_slot           = res_slot_q;
    assign result_stb            = res_stb_q;
    assign seq_done              = seq_done_q;
    assign busy                  = (state_q != IDLE);
    assign overrun               = overrun_q;
    assign chan_err              = chan_err_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer: ADC responder, transaction-level
// reference model, config table and directed corner-case sequences.
module tb_adc_sequencer;

    localparam int NS = 4;
    localparam int DW = 12;
    localparam int PW = 16;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [NS*CW-1:0]  slot_channels = '0;
    logic [2:0]        slot_count = '0;
    logic [PW-1:0]     sample_period = '0;
    logic              clear_flags = 1'b0;
    logic              command_valid;
    logic [CW-1:0]     command_channel;
    logic              command_startofpacket;
    logic              command_endofpacket;
    logic              command_ready = 1'b0;
    logic              response_valid = 1'b0;
    logic [CW-1:0]     response_channel = '0;
    logic [DW-1:0]     response_data = '0;
    logic [NS*DW-1:0]  result_data;
    logic [2:0]        result_slot;
    logic              result_stb;
    logic              seq_done;
    logic              busy;
    logic              overrun;
    logic              chan_err;

    always #5 clk = ~clk;

    adc_sequencer #(.NUM_SLOTS(NS), .DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable                (enable),
        .slot_channels         (slot_channels),
        .slot_count            (slot_count),
        .sample_period         (sample_period),
        .clear_flags           (clear_flags),
        .command_valid         (command_valid),
        .command_channel       (command_channel),
        .command_startofpacket (command_startofpacket),
        .command_endofpacket   (command_endofpacket),
        .command_ready         (command_ready),
        .response_valid        (response_valid),
        .response_channel      (response_channel),
        .response_data         (response_data),
        .result_data           (result_data),
        .result_slot           (result_slot),
        .result_stb            (result_stb),
        .seq_done              (seq_done),
        .busy                  (busy),
        .overrun               (overrun),
        .chan_err              (chan_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Reference model: one sequence = cnt conversions, counted issued/answered
    bit            m_busy;
    int            m_cnt, m_iss, m_taken, m_en, m_slot;
    logic [CW-1:0] m_ch  [NS];
    logic [DW-1:0] m_res [NS];
    bit            m_ov, m_ce, e_stb, e_done;

    typedef struct {
        logic [CW-1:0] ch;
        int            due;
    } pend_t;
    pend_t pq[$];

    int            lat = 2;
    int            rdy_mode = 0;
    bit            force_bad = 0;
    bit            spur = 0;
    int            acc_cnt = 0;
    int            stb_cnt = 0;
    bit            last_eop = 0;
    bit            done_seen = 0;
    bit            prev_valid = 0;
    int            start_cyc[$];
    logic [DW-1:0] last_rdata = '0;

    typedef struct {
        logic [2:0] sc;
        int         exp_cmds;
    } row_t;
    row_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_cnt = 0; m_iss = 0; m_taken = 0; m_en = 0; m_slot = 0;
        m_ov = 0; m_ce = 0; e_stb = 0; e_done = 0;
        for (int k = 0; k < NS; k++) begin
            m_ch[k]  = '0;
            m_res[k] = '0;
        end
    endfunction

    // Advance the model across the coming rising edge using the inputs now applied.
    task automatic model_edge();
        bit tick, take, orphan, bad, done_now, start_now;
        int cl;
        tick = enable && ((m_en % (int'(sample_period) + 1)) == int'(sample_period));
        m_en = enable ? m_en + 1 : 0;
        cl = (int'(slot_count) > NS) ? NS : int'(slot_count);
        take = response_valid && (m_taken < m_iss);
        orphan = response_valid && !take;
        bad = 0;
        done_now = m_busy && (m_iss == m_cnt) && (m_taken == m_cnt);
        start_now = !m_busy && tick && (cl != 0);
        e_stb = 0;
        e_done = 0;
        if (take) begin
            bad = (response_channel != m_ch[m_taken]);
            m_res[m_taken] = response_data;
            m_slot = m_taken;
            e_stb = 1;
            m_taken++;
        end
        if (m_busy && (m_iss < m_cnt) && command_ready) m_iss++;
        if (tick && m_busy) m_ov = 1;
        else if (clear_flags) m_ov = 0;
        if (orphan || bad) m_ce = 1;
        else if (clear_flags) m_ce = 0;
        if (done_now) begin
            m_busy = 0;
            e_done = 1;
        end
        if (start_now) begin
            for (int k = 0; k < NS; k++) m_ch[k] = slot_channels[k*CW +: CW];
            m_busy = 1;
            m_cnt = cl;
            m_iss = 0;
            m_taken = 0;
        end
    endtask

    task automatic check_outputs();
        logic [NS*DW-1:0] ev;
        bit exp_v;
        exp_v = m_busy && (m_iss < m_cnt);
        chk("command_valid", command_valid, exp_v);
        if (exp_v) begin
            chk("command_channel", command_channel, m_ch[m_iss]);
            chk("command_sop", command_startofpacket, m_iss == 0);
            chk("command_eop", command_endofpacket, m_iss == m_cnt - 1);
        end
        for (int k = 0; k < NS; k++) ev[k*DW +: DW] = m_res[k];
        chk("busy", busy, m_busy);
        chk("result_stb", result_stb, e_stb);
        chk("result_slot", result_slot, m_slot);
        chk("result_data", result_data, ev);
        chk("seq_done", seq_done, e_done);
        chk("overrun", overrun, m_ov);
        chk("chan_err", chan_err, m_ce);
    endtask

    // One clock: drive ADC side, update model, then sample at the falling edge.
    task automatic step();
        pend_t p;
        case (rdy_mode)
            0:       command_ready = 1'b1;
            1:       command_ready = 1'($urandom_range(0, 1));
            default: command_ready = 1'b0;
        endcase
        response_valid = 1'b0;
        response_channel = '0;
        response_data = '0;
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            response_valid = 1'b1;
            response_channel = force_bad ? 5'd7 : p.ch;
            force_bad = 0;
            response_data = DW'($urandom);
            last_rdata = response_data;
        end else if (spur) begin
            response_valid = 1'b1;
            response_channel = CW'($urandom);
            response_data = DW'($urandom);
            spur = 0;
        end
        if (command_valid && command_ready) begin
            p.ch = command_channel;
            p.due = cyc + lat;
            pq.push_back(p);
            acc_cnt++;
            last_eop = command_endofpacket;
        end
        if (command_valid && !prev_valid) start_cyc.push_back(cyc);
        prev_valid = command_valid;
        model_edge();
        @(negedge clk);
        cyc++;
        check_outputs();
        if (result_stb) stb_cnt++;
        if (seq_done) done_seen = 1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_seq(input string name, input int budget);
        int i;
        i = 0;
        done_seen = 0;
        while (!done_seen && i < budget) begin
            step();
            i++;
        end
        chk(name, done_seen, 1);
    endtask

    task automatic pulse_clear();
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS*CW-1:0] cfg;
        int i, spacing, snap, n;

        tbl[0] = '{3'd1, 1};
        tbl[1] = '{3'd2, 2};
        tbl[2] = '{3'd4, 4};
        tbl[3] = '{3'd5, 4};
        tbl[4] = '{3'd7, 4};
        tbl[5] = '{3'd0, 0};

        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: two slots, period 99, ADC latency 2
        cfg = '0;
        cfg[4:0] = 5'd1;
        cfg[9:5] = 5'd3;
        slot_channels = cfg;
        slot_count = 3'd2;
        sample_period = PW'(99);
        lat = 2;
        rdy_mode = 0;
        stb_cnt = 0;
        start_cyc.delete();
        enable = 1'b1;
        run_seq("basic_seq1", 150);
        run_seq("basic_seq2", 150);
        spacing = (start_cyc.size() >= 2) ? start_cyc[1] - start_cyc[0] : -1;
        chk("basic_tick_spacing", spacing, 100);
        chk("basic_results", stb_cnt, 4);
        enable = 1'b0;
        step();

        // Slot count table: zero, in-range and clamped counts
        for (int r = 0; r < 6; r++) begin
            enable = 1'b0;
            slot_count = tbl[r].sc;
            slot_channels = (NS*CW)'($urandom);
            sample_period = PW'($urandom_range(2, 6));
            step();
            acc_cnt = 0;
            last_eop = 0;
            enable = 1'b1;
            if (tbl[r].exp_cmds > 0) run_seq("tbl_done", 100);
            else run(30);
            enable = 1'b0;
            step();
            chk("tbl_cmds", acc_cnt, tbl[r].exp_cmds);
            if (tbl[r].exp_cmds > 0) chk("tbl_eop", last_eop, 1);
        end
        pulse_clear();

        // Backpressure on slot 1, with config changed mid-sequence
        cfg = (NS*CW)'($urandom);
        slot_channels = cfg;
        slot_count = 3'd4;
        sample_period = PW'(300);
        step();
        acc_cnt = 0;
        stb_cnt = 0;
        enable = 1'b1;
        i = 0;
        while (acc_cnt < 1 && i < 400) begin
            step();
            i++;
        end
        chk("bp_start", acc_cnt, 1);
        rdy_mode = 2;
        slot_channels = ~cfg;
        repeat (5) begin
            step();
            chk("bp_valid", command_valid, 1);
            chk("bp_chan", command_channel, cfg[9:5]);
            chk("bp_eop", command_endofpacket, 0);
        end
        rdy_mode = 0;
        run_seq("bp_done", 100);
        chk("bp_cmds", acc_cnt, 4);
        chk("bp_results", stb_cnt, 4);
        enable = 1'b0;
        step();

        // Overrun: short period, slow ADC
        pulse_clear();
        slot_channels = (NS*CW)'($urandom);
        slot_count = 3'd2;
        sample_period = PW'(3);
        lat = 10;
        step();
        enable = 1'b1;
        run_seq("ovr_done", 100);
        chk("ovr_flag", overrun, 1);
        enable = 1'b0;
        lat = 2;
        step();
        pulse_clear();
        chk("ovr_clear", overrun, 0);

        // Channel error, then a spurious response while idle
        cfg = '0;
        cfg[4:0] = 5'd1;
        slot_channels = cfg;
        slot_count = 3'd1;
        sample_period = PW'(4);
        force_bad = 1;
        step();
        enable = 1'b1;
        run_seq("ce_done", 50);
        enable = 1'b0;
        step();
        chk("ce_flag", chan_err, 1);
        chk("ce_slot0_data", result_data[DW-1:0], last_rdata);
        chk("ce_slot_idx", result_slot, 0);
        pulse_clear();
        chk("ce_clear", chan_err, 0);
        snap = stb_cnt;
        spur = 1;
        run(3);
        chk("spur_flag", chan_err, 1);
        chk("spur_no_stb", stb_cnt, snap);
        chk("spur_slot0_kept", result_data[DW-1:0], last_rdata);

        // Randomized traffic against the model
        pulse_clear();
        rdy_mode = 1;
        for (int it = 0; it < 40; it++) begin
            enable = 1'b0;
            sample_period = PW'($urandom_range(0, 15));
            slot_count = 3'($urandom_range(0, 7));
            slot_channels = (NS*CW)'($urandom);
            lat = $urandom_range(1, 5);
            step();
            enable = 1'b1;
            n = $urandom_range(20, 60);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 6) == 0) slot_channels = (NS*CW)'($urandom);
                if ($urandom_range(0, 10) == 0) slot_count = 3'($urandom_range(0, 7));
                clear_flags = ($urandom_range(0, 12) == 0);
                if ($urandom_range(0, 16) == 0) spur = 1;
                if ($urandom_range(0, 18) == 0) force_bad = 1;
                step();
            end
            clear_flags = 1'b0;
        end
        enable = 1'b0;
        rdy_mode = 0;
        run(40);

        // Reset in the middle of ISSUE
        pulse_clear();
        slot_count = 3'd3;
        slot_channels = (NS*CW)'($urandom);
        sample_period = PW'(5);
        rdy_mode = 2;
        step();
        enable = 1'b1;
        i = 0;
        while (!command_valid && i < 50) begin
            step();
            i++;
        end
        chk("rst_valid_before", command_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", command_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_results", result_data, 0);
        chk("rst_flags", {overrun, chan_err}, 0);
        pq.delete();
        model_reset();
        prev_valid = 0;
        force_bad = 0;
        spur = 0;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        i = 0;
        while (!command_valid && i < 50) begin
            step();
            i++;
        end
        chk("rst_first_tick", i, 6);
        run_seq("rst_seq_done", 50);
        enable = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
